buffer_de_escrita: RTL
======================

BUFFER_DE_ESCRITA -- requirements
Module: buffer_de_escrita

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_addr  input  16  byte address of the pipeline load/store.
REQ-005 SHALL have port cpu_wdata  input  16  store data.
REQ-006 SHALL have port cpu_write  input  1  store request this cycle.
REQ-007 SHALL have port cpu_read  input  1  load request this cycle.
REQ-008 SHALL have port cpu_rdata  output  16  load result, combinational.
REQ-009 SHALL have port cpu_stall  output  1  store not accepted this cycle; pipeline holds it.
REQ-010 SHALL have port buf_empty  output  1  no pending stores.
REQ-011 SHALL have port mem_access_addr  output  16  address to data memory.
REQ-012 SHALL have port mem_write_data  output  16  write data to data memory.
REQ-013 SHALL have port mem_write_en  output  1  data memory write strobe.
REQ-014 SHALL have port mem_read  output  1  data memory read enable.
REQ-015 SHALL have port mem_read_data  input  16  data memory combinational read result.

Function
REQ-016 SHALL hold a circular queue of DEPTH entries {addr[15:0], data[15:0]} with head pointer, tail pointer and count (0..DEPTH), stores leaving in acceptance order.
REQ-017 SHALL treat two addresses as matching when bits [8:1] are equal (word address used by the data memory); bits [15:9] and [0] are ignored.
REQ-018 SHALL assert cpu_stall combinationally when cpu_write=1 and count=DEPTH, regardless of a same-cycle drain.
REQ-019 SHALL accept a store (write entry at tail, advance tail mod DEPTH) on the clock edge when cpu_write=1 and cpu_stall=0.
REQ-020 SHALL drive the memory port for a load when cpu_read=1: mem_read=1, mem_access_addr=cpu_addr, mem_write_en=0; loads have absolute priority over draining.
REQ-021 SHALL drain when cpu_read=0 and count>0: mem_write_en=1, mem_access_addr=head addr, mem_write_data=head data, mem_read=0; head advances mod DEPTH on that edge.
REQ-022 SHALL drive mem_access_addr=0, mem_write_data=0, mem_write_en=0, mem_read=0 when neither load nor drain occurs.
REQ-023 SHALL, on a load, return on cpu_rdata the data of the youngest valid entry matching cpu_addr, else mem_read_data; cpu_rdata=0 when cpu_read=0.
REQ-024 SHALL exclude the store being accepted in the same cycle from load forwarding (load sees state before the edge).
REQ-025 SHALL update count: +1 on accept only, -1 on drain only, unchanged on accept plus drain in the same cycle.
REQ-026 SHALL give a store a minimum latency of one cycle: accepted at edge N, written to memory at earliest edge N+1.
REQ-027 SHALL assert buf_empty combinationally when count=0.
REQ-028 SHALL never drain and accept into the same slot incorrectly: with count=DEPTH a drain frees a slot that becomes usable only from the next cycle.

Reset
REQ-029 SHALL, while rst_n=0, clear head, tail and count to 0 immediately, independent of clk.
REQ-030 SHALL discard all pending stores on reset mid-operation; they are never written to memory.
REQ-031 SHALL present after reset: cpu_stall=0, buf_empty=1, mem_write_en=0, mem_read=0, mem_access_addr=0, mem_write_data=0, cpu_rdata=0 (inputs idle).
REQ-032 SHALL resume normal operation on the first rising clk edge after rst_n rises.

Verification
REQ-033 SHALL cover: store addr 0x0010 data 0xABCD, no loads -> next cycle mem_write_en=1, mem_access_addr=0x0010, mem_write_data=0xABCD; then buf_empty=1.
REQ-034 SHALL cover: cpu_read held high while 4 stores accepted -> 5th store sees cpu_stall=1, count stays 4, mem_write_en=0 throughout.
REQ-035 SHALL cover: stores 0x0020<-0x1111 then 0x0021<-0x2222 with cpu_read held, then load 0x0020 -> cpu_rdata=0x2222 (youngest match on bits [8:1]).
REQ-036 SHALL cover: load 0x0040 with no matching entry, memory holding 0x5A5A -> cpu_rdata=0x5A5A, mem_read=1.
REQ-037 SHALL cover: count=2, rst_n pulsed low between edges -> buf_empty=1 at once, no memory write of discarded entries afterwards.
REQ-038 SHALL cover: count=DEPTH, cpu_read=0, cpu_write=1 -> cpu_stall=1, drain occurs, count=DEPTH-1; store re-presented next cycle accepted, count=DEPTH.

Source files
------------

// File: rtl/buffer_de_escrita.sv
// Write buffer between the pipeline and a single-port data memory.
// Stores queue up and drain in order while the port is free; loads take the port and forward from pending stores.
`timescale 1ns/1ps

module buffer_de_escrita #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_write,
    input  logic        cpu_read,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        buf_empty,
    output logic [15:0] mem_access_addr,
    output logic [15:0] mem_write_data,
    output logic        mem_write_en,
    output logic        mem_read,
    input  logic [15:0] mem_read_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   addr_q [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          accept;
    logic          drain;
    logic          fwd_hit;
    logic [15:0]   fwd_data;

    // A full buffer stalls even if a drain frees a slot this cycle; the slot is reusable next cycle.
    assign full      = (count_q == CW'(DEPTH));
    assign cpu_stall = cpu_write && full;
    assign accept    = cpu_write && !full;
    assign drain     = !cpu_read && (count_q != '0);
    assign buf_empty = (count_q == '0);

    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (cpu_read) begin
            mem_read        = 1'b1;
            mem_access_addr = cpu_addr;
        end else if (drain) begin
            mem_write_en    = 1'b1;
            mem_access_addr = addr_q[head_q];
            mem_write_data  = data_q[head_q];
        end
    end

    // Walk entries oldest to youngest so the last match wins; only word address bits take part.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) &&
                (addr_q[head_q + PW'(i)][8:1] == cpu_addr[8:1])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PW'(i)];
            end
        end
    end

    assign cpu_rdata = !cpu_read ? 16'h0000 : (fwd_hit ? fwd_data : mem_read_data);

    always_comb begin
        head_d  = drain  ? head_q + PW'(1) : head_q;
        tail_d  = accept ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({accept, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[tail_q] <= cpu_addr;
            data_q[tail_q] <= cpu_wdata;
        end
    end

endmodule
